hilo_muldiv_seq: RTL and testbench

- Multi-cycle sequencer for the HI/LO multiply/divide resource. It replaces single-cycle MULT/MULTU/DIV/DIVU evaluation with a 32-iteration shift-add multiplier and a restoring divider.
- Sits beside the execute stage. The execute stage issues a request; this block writes HI/LO when the operation finishes.
- Generates the pipeline interlock for MFHI/MFLO and for back-to-back HI/LO operations.

---
 rtl/hilo_muldiv_seq_if.sv | 29 ++
 rtl/hilo_muldiv_seq.sv | 206 ++++++++++++++++++++
 tb/tb_hilo_muldiv_seq.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_seq_if.sv
// Execute-stage <-> HI/LO multiply/divide sequencer bundle.
// The master drives the request side; the slave returns interlock and HI/LO write strobes.
interface hilo_muldiv_seq_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             hilo_read;
    logic             busy;
    logic             stall;
    logic [WIDTH-1:0] wHiData;
    logic [WIDTH-1:0] wLoData;
    logic             whi;
    logic             wlo;
    logic             done;

    modport master (
        output start, op, a, b, cancel, hilo_read,
        input  busy, stall, wHiData, wLoData, whi, wlo, done
    );

    modport slave (
        input  start, op, a, b, cancel, hilo_read,
        output busy, stall, wHiData, wLoData, whi, wlo, done
    );
endinterface

// File: rtl/hilo_muldiv_seq.sv
// Multi-cycle HI/LO sequencer: 32-step shift-add multiplier and restoring divider
// for MULT/MULTU/DIV/DIVU, with the MFHI/MFLO and back-to-back interlock.
module hilo_muldiv_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic              clk,
    input logic              rst,
    hilo_muldiv_seq_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StPrep, StCalc, StDone} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic                   sign_a_q, sign_a_d;
    logic                   sign_b_q, sign_b_d;
    logic [WIDTH-1:0]       dsr_q, dsr_d;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]     prod_q, prod_d;
    logic [WIDTH:0]         rem_q, rem_d;
    logic [WIDTH-1:0]       quo_q, quo_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   whi_q, whi_d;
    logic                   wlo_q, wlo_d;
    logic                   done_q, done_d;

    logic                   is_signed;
    logic                   is_div;
    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_nxt;
    logic [WIDTH+1:0]       div_part;
    logic [WIDTH+1:0]       div_diff;
    logic [WIDTH:0]         rem_nxt;
    logic [WIDTH-1:0]       quo_nxt;
    logic                   neg_res;
    logic [2*WIDTH-1:0]     prod_fin;
    logic [WIDTH-1:0]       quo_fin;
    logic [WIDTH-1:0]       rem_fin;

    assign is_signed = ~op_q[0];
    assign is_div    = op_q[1];
    assign mag_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    assign mag_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    // Multiplier LSB sits at prod_q[0]; the upper half accumulates with carry-out.
    assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, dsr_q};
    assign mul_nxt = prod_q[0] ? {mul_sum, prod_q[WIDTH-1:1]} : {1'b0, prod_q[2*WIDTH-1:1]};

    assign div_part = {rem_q, quo_q[WIDTH-1]};
    assign div_diff = div_part - {2'b00, dsr_q};

    always_comb begin
        rem_nxt = div_part[WIDTH:0];
        quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
        if (!div_diff[WIDTH+1]) begin
            rem_nxt = div_diff[WIDTH:0];
            quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign neg_res  = sign_a_q ^ sign_b_q;
    assign prod_fin = neg_res ? -mul_nxt : mul_nxt;
    assign quo_fin  = neg_res ? -quo_nxt : quo_nxt;
    assign rem_fin  = sign_a_q ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dsr_d    = dsr_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        whi_d    = 1'b0;
        wlo_d    = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.cancel) begin
                    state_d = StPrep;
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                end
            end
            StPrep: begin
                if (bus.cancel) begin
                    state_d = StIdle;
                end else begin
                    sign_a_d = is_signed & a_q[WIDTH-1];
                    sign_b_d = is_signed & b_q[WIDTH-1];
                    cnt_d    = '0;
                    if (is_div) begin
                        dsr_d = mag_b;
                        rem_d = '0;
                        quo_d = mag_a;
                        if (b_q == '0) begin
                            // Divide-by-zero: report completion, leave HI/LO untouched.
                            state_d = StDone;
                            done_d  = 1'b1;
                            lo_d    = '1;
                            hi_d    = a_q;
                        end else begin
                            state_d = StCalc;
                        end
                    end else begin
                        dsr_d   = mag_a;
                        prod_d  = {{WIDTH{1'b0}}, mag_b};
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (bus.cancel) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_div) begin
                        rem_d = rem_nxt;
                        quo_d = quo_nxt;
                    end else begin
                        prod_d = mul_nxt;
                    end
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        whi_d   = 1'b1;
                        wlo_d   = 1'b1;
                        if (is_div) begin
                            hi_d = rem_fin;
                            lo_d = quo_fin;
                        end else begin
                            hi_d = prod_fin[2*WIDTH-1:WIDTH];
                            lo_d = prod_fin[WIDTH-1:0];
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dsr_q    <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            whi_q    <= 1'b0;
            wlo_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dsr_q    <= dsr_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            whi_q    <= whi_d;
            wlo_q    <= wlo_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy    = (state_q != StIdle);
    assign bus.stall   = bus.busy & (bus.start | bus.hilo_read);
    assign bus.wHiData = hi_q;
    assign bus.wLoData = lo_q;
    assign bus.whi     = whi_q;
    assign bus.wlo     = wlo_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Directed and randomized checks of hilo_muldiv_seq against a plain-arithmetic
// model of MULT/MULTU/DIV/DIVU, including latency, interlock, cancel and reset.
module tb_hilo_muldiv_seq;
    localparam int unsigned W = 32;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          failures = 0;
    int          lat;
    logic [31:0] obs_hi;
    logic [31:0] obs_lo;
    logic        seen;

    hilo_muldiv_seq_if #(.WIDTH(W)) bus ();

    hilo_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: 64-bit host arithmetic; SV division truncates toward zero and
    // the remainder takes the dividend's sign, matching the instruction set.
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] hi,
                                      output logic [31:0] lo, output logic div0);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          p;
        longint unsigned up;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ua   = {32'd0, a};
        ub   = {32'd0, b};
        div0 = 1'b0;
        hi   = '0;
        lo   = '0;
        if (op[1] && b == 32'd0) begin
            div0 = 1'b1;
            hi   = a;
            lo   = 32'hFFFF_FFFF;
        end else begin
            case (op)
                2'd0: begin p = sa * sb; {hi, lo} = p; end
                2'd1: begin up = ua * ub; {hi, lo} = up; end
                2'd2: begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
                default: begin lo = 32'(ua / ub); hi = 32'(ua % ub); end
            endcase
        end
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
        return $urandom();
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
    endtask

    // Counts edges from the sampling edge until done; start drops after the first edge.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            step();
            n++;
            bus.start = 1'b0;
        end while (!bus.done && n < 40);
    endtask

    task automatic run_check(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic        e_div0;
        string       id;
        ref_model(op, a, b, e_hi, e_lo, e_div0);
        id = $sformatf("op%0d a=%h b=%h", op, a, b);
        issue(op, a, b);
        wait_done(lat);
        chk({"latency ", id}, lat, e_div0 ? 2 : 34);
        chk({"done ", id}, bus.done, 1'b1);
        chk({"whi ", id}, bus.whi, !e_div0);
        chk({"wlo ", id}, bus.wlo, !e_div0);
        obs_hi = bus.wHiData;
        obs_lo = bus.wLoData;
        chk({"hi ", id}, obs_hi, e_hi);
        chk({"lo ", id}, obs_lo, e_lo);
        step();
        chk({"done_clear ", id}, bus.done, 1'b0);
        chk({"idle_after ", id}, bus.busy, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.op        = 2'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cancel    = 1'b0;
        bus.hilo_read = 1'b0;
        repeat (2) step();
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_whi", bus.whi, 1'b0);
        chk("rst_wlo", bus.wlo, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_hi", bus.wHiData, 32'h0);
        chk("rst_lo", bus.wLoData, 32'h0);
        rst = 1'b0;
        step();

        // Directed arithmetic with hand-computed results.
        run_check(2'd0, 32'hFFFF_FFFE, 32'd3);
        chk("mult_hi", obs_hi, 32'hFFFF_FFFF);
        chk("mult_lo", obs_lo, 32'hFFFF_FFFA);
        run_check(2'd1, 32'hFFFF_FFFE, 32'd3);
        chk("multu_hi", obs_hi, 32'h0000_0002);
        chk("multu_lo", obs_lo, 32'hFFFF_FFFA);
        run_check(2'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_hi", obs_hi, 32'hFFFF_FFFF);
        chk("div_lo", obs_lo, 32'hFFFF_FFFD);
        run_check(2'd3, 32'd7, 32'd2);
        chk("divu_hi", obs_hi, 32'd1);
        chk("divu_lo", obs_lo, 32'd3);
        run_check(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_hi", obs_hi, 32'h0);
        chk("div_ovf_lo", obs_lo, 32'h8000_0000);
        run_check(2'd3, 32'h1234_5678, 32'd0);
        chk("div0_lo", obs_lo, 32'hFFFF_FFFF);

        // Interlock and ignored requests while idle.
        bus.hilo_read = 1'b1;
        #1;
        chk("idle_read_stall", bus.stall, 1'b0);
        bus.hilo_read = 1'b0;
        issue(2'd0, 32'd5, 32'd6);
        bus.cancel = 1'b1;
        step();
        chk("cancel_start_idle", bus.busy, 1'b0);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;

        // hilo_read while busy, and during the DONE cycle.
        issue(2'd1, 32'd9, 32'd11);
        step();
        bus.start     = 1'b0;
        bus.hilo_read = 1'b1;
        #1;
        chk("busy_read_stall", bus.stall, 1'b1);
        bus.hilo_read = 1'b0;
        #1;
        chk("busy_noreq_stall", bus.stall, 1'b0);
        wait_done(lat);
        chk("held_latency", lat, 33);
        chk("held_lo", bus.wLoData, 32'd99);
        bus.hilo_read = 1'b1;
        #1;
        chk("done_read_stall", bus.stall, 1'b1);
        step();
        chk("post_done_read_stall", bus.stall, 1'b0);
        bus.hilo_read = 1'b0;

        // Back-to-back: second request raised five cycles into the first.
        issue(2'd1, 32'h0001_0000, 32'h0001_0000);
        step();
        bus.start = 1'b0;
        repeat (4) step();
        issue(2'd3, 32'd7, 32'd2);
        lat = 0;
        do begin
            #1;
            chk("b2b_stall", bus.stall, 1'b1);
            step();
            lat++;
        end while (!bus.done && lat < 40);
        chk("b2b_first_done", bus.done, 1'b1);
        chk("b2b_first_hi", bus.wHiData, 32'h1);
        chk("b2b_first_lo", bus.wLoData, 32'h0);
        step();
        chk("b2b_idle_stall", bus.stall, 1'b0);
        chk("b2b_idle_busy", bus.busy, 1'b0);
        wait_done(lat);
        chk("b2b_second_latency", lat, 34);
        chk("b2b_second_hi", bus.wHiData, 32'd1);
        chk("b2b_second_lo", bus.wLoData, 32'd3);
        step();

        // Cancel at CALC iteration 10.
        issue(2'd3, 32'hDEAD_BEEF, 32'd3);
        step();
        bus.start = 1'b0;
        step();
        repeat (10) step();
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        chk("cancel_busy", bus.busy, 1'b0);
        chk("cancel_done", bus.done, 1'b0);
        chk("cancel_whi", bus.whi, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            step();
            seen = seen | bus.done | bus.whi | bus.wlo;
        end
        chk("cancel_no_write", seen, 1'b0);

        // Reset at CALC iteration 20.
        issue(2'd0, 32'h1357_9BDF, 32'h2468_ACE0);
        step();
        bus.start = 1'b0;
        step();
        repeat (20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        chk("midrst_whi", bus.whi, 1'b0);
        chk("midrst_wlo", bus.wlo, 1'b0);
        chk("midrst_hi", bus.wHiData, 32'h0);
        chk("midrst_lo", bus.wLoData, 32'h0);
        seen = 1'b0;
        repeat (40) begin
            step();
            seen = seen | bus.done | bus.whi | bus.wlo;
        end
        chk("midrst_no_write", seen, 1'b0);

        // Randomized operands across all four operations.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 400; i++) begin
                run_check(2'(t), pick(), pick());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
